regfile_multiport: RTL and testbench

//  Parametrised integer register file for the RV32 core: NRD combinational read ports, one write port.

---
 rtl/rf_pkg.sv | 10 +
 rtl/rf_clear_seq.sv | 63 ++++++
 rtl/regfile_multiport.sv | 84 ++++++++
 tb/tb_regfile_multiport.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and defaults for the multiport integer register file.
// No logic; imported by the clear sequencer and the register file top.
// Optional write-to-read forwarding is selected with the RF_BYPASS_EN macro.
package rf_pkg;

  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_e;

  localparam int XLEN_DEFAULT = 32;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: sweeps one register entry per cycle after reset or a clear request.
// Latency: busy rises the cycle after clr_req; a sweep lasts exactly NREGS cycles.
// Backpressure: busy is the stall signal; clr_req is ignored while a sweep is running.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  // State and sweep counter; the sweep restarts from entry 0 whenever reset is asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and outputs: CLEAR writes zero to entry cnt_q, RUN waits for a clear pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    clr_we   = 1'b0;
    clr_addr = cnt_q;
    case (state_q)
      RF_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = RF_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      RF_RUN: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RF_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_multiport.sv
// RV32 integer register file: NRD combinational read ports, one write port, x0 hardwired to zero.
// Latency: reads are combinational; writes land on the clock edge (same-cycle forwarding with RF_BYPASS_EN).
// Backpressure: busy stalls the pipeline during a clear sweep; writes and reads are masked while busy.
module regfile_multiport
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clr_req,
  output logic                      busy,
  input  logic                      we,
  input  logic [AW-1:0]             wr_addr,
  input  logic [XLEN-1:0]           wr_data,
  input  logic [NRD-1:0][AW-1:0]    rd_addr,
  output logic [NRD-1:0][XLEN-1:0]  rd_data
);

  logic [XLEN-1:0] mem [NREGS];

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  // Addresses are compared one bit wider so non-power-of-two NREGS still rejects the top codes.
  function automatic logic in_range(input logic [AW-1:0] addr);
    return {1'b0, addr} < (AW + 1)'(NREGS);
  endfunction

  rf_clear_seq #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clear_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Write mux: the sweep owns the port while busy; otherwise drop writes to x0 or out-of-range entries.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (busy) begin
      mem_we    = clr_we;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else begin
      mem_we = we && (wr_addr != '0) && in_range(wr_addr);
    end
  end

  // Storage array kept free of reset so it can map onto RAM; the sweep provides the clear.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read ports: zero for x0, out-of-range or during a sweep; optional forwarding of the in-flight write.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_data[i] = '0;
      if (!busy && (rd_addr[i] != '0) && in_range(rd_addr[i])) begin
        rd_data[i] = mem[rd_addr[i]];
`ifdef RF_BYPASS_EN
        if (we && (wr_addr == rd_addr[i])) begin
          rd_data[i] = wr_data;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: default instance (32 entries, 2 ports) and a 16-entry, 3-port instance.
// Inputs change 1ns after the rising edge; outputs are sampled before the next edge.
// Reference model: plain arrays of register contents plus the read rules.
module tb_regfile_multiport;

  logic              clk = 1'b0;
  logic              rst_n, clr, we;
  logic [4:0]        wa;
  logic [31:0]       wd;
  logic [1:0][4:0]   ra;
  logic [1:0][31:0]  rd;
  logic              busy;

  logic              rst2_n, clr2, we2;
  logic [3:0]        wa2;
  logic [31:0]       wd2;
  logic [2:0][3:0]   ra2;
  logic [2:0][31:0]  rd2;
  logic              busy2;

  logic [31:0] mem_m  [32];
  logic [31:0] mem2_m [16];
  int pass_cnt = 0;
  int tot_cnt  = 0;

  regfile_multiport dut (
    .clk(clk), .reset_n(rst_n), .clr_req(clr), .busy(busy), .we(we),
    .wr_addr(wa), .wr_data(wd), .rd_addr(ra), .rd_data(rd)
  );

  regfile_multiport #(.NREGS(16), .NRD(3)) dut2 (
    .clk(clk), .reset_n(rst2_n), .clr_req(clr2), .busy(busy2), .we(we2),
    .wr_addr(wa2), .wr_data(wd2), .rd_addr(ra2), .rd_data(rd2)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected read of the default instance given the current write-port inputs.
  function automatic logic [31:0] exp_rd(input int a, input logic w, input int wadr, input logic [31:0] wdat);
    if (a == 0 || a >= 32) return 32'h0;
`ifdef RF_BYPASS_EN
    if (w && wadr == a) return wdat;
`endif
    return mem_m[a];
  endfunction

  task automatic test_reset();
    int cyc;
    ra[0] = 5'd5; ra[1] = 5'd31;
    tick(); tick();
    tot_cnt++;
    if (busy !== 1'b1 || rd !== 64'h0) $display("FAIL reset_state: got busy=%b rd=%h expected busy=1 rd=0", busy, rd);
    else pass_cnt++;
    rst_n = 1'b1; rst2_n = 1'b1;
    cyc = 0;
    while (busy && cyc < 100) begin tick(); cyc++; end
    tot_cnt++;
    if (cyc !== 32) $display("FAIL reset_sweep_len: got %0d cycles expected 32", cyc);
    else pass_cnt++;
    tot_cnt++;
    if (busy2 !== 1'b0) $display("FAIL reset_sweep_len2: got busy2=%b expected 0", busy2);
    else pass_cnt++;
    for (int a = 0; a < 32; a++) begin
      ra[0] = 5'(a); ra[1] = 5'(31 - a);
      #1;
      tot_cnt++;
      if (rd !== 64'h0) $display("FAIL reset_read_zero: addr %0d got %h expected 0", a, rd);
      else pass_cnt++;
    end
    for (int a = 0; a < 32; a++) mem_m[a] = 32'h0;
    for (int a = 0; a < 16; a++) mem2_m[a] = 32'h0;
  endtask

  task automatic test_write_read();
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    tick();
    mem_m[5] = 32'hDEADBEEF;
    we = 1'b0; ra[0] = 5'd5; ra[1] = 5'd5;
    #1;
    tot_cnt++;
    if (rd[0] !== 32'hDEADBEEF || rd[1] !== 32'hDEADBEEF)
      $display("FAIL write_read_x5: got %h/%h expected deadbeef/deadbeef", rd[0], rd[1]);
    else pass_cnt++;
  endtask

  task automatic test_x0();
    we = 1'b1; wa = 5'd0; wd = 32'h12345678; ra[0] = 5'd0;
    #1;
    tot_cnt++;
    if (rd[0] !== 32'h0) $display("FAIL x0_same_cycle: got %h expected 0", rd[0]);
    else pass_cnt++;
    tick();
    we = 1'b0;
    #1;
    tot_cnt++;
    if (rd[0] !== 32'h0) $display("FAIL x0_next_cycle: got %h expected 0", rd[0]);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    logic [31:0] e;
    we = 1'b1; wa = 5'd7; wd = 32'h11;
    tick();
    mem_m[7] = 32'h11;
    wd = 32'h22; ra[0] = 5'd7;
    #1;
`ifdef RF_BYPASS_EN
    e = 32'h22;
`else
    e = 32'h11;
`endif
    tot_cnt++;
    if (rd[0] !== e) $display("FAIL bypass_same_cycle: got %h expected %h", rd[0], e);
    else pass_cnt++;
    tick();
    mem_m[7] = 32'h22;
    we = 1'b0;
    #1;
    tot_cnt++;
    if (rd[0] !== 32'h22) $display("FAIL bypass_next_cycle: got %h expected 22", rd[0]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int wadr, a0, a1;
    logic w;
    logic [31:0] dat, e0, e1;
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom_range(0, 1));
      wadr = $urandom_range(0, 31);
      dat = $urandom;
      a0 = ($urandom_range(0, 3) == 0) ? wadr : $urandom_range(0, 31);
      a1 = ($urandom_range(0, 3) == 0) ? wadr : $urandom_range(0, 31);
      we = w; wa = 5'(wadr); wd = dat; ra[0] = 5'(a0); ra[1] = 5'(a1);
      #1;
      e0 = exp_rd(a0, w, wadr, dat);
      e1 = exp_rd(a1, w, wadr, dat);
      tot_cnt++;
      if (rd[0] !== e0 || rd[1] !== e1)
        $display("FAIL random_read: iter %0d addr %0d/%0d got %h/%h expected %h/%h", n, a0, a1, rd[0], rd[1], e0, e1);
      else pass_cnt++;
      tick();
      if (w && wadr != 0) mem_m[wadr] = dat;
    end
    we = 1'b0;
  endtask

  task automatic test_clear();
    int cyc;
    we = 1'b1; wa = 5'd3; wd = 32'hA;
    tick();
    clr = 1'b1; wa = 5'd4; wd = 32'hB;
    tick();
    clr = 1'b0; we = 1'b0;
    tot_cnt++;
    if (busy !== 1'b1) $display("FAIL clear_busy_rise: got %b expected 1", busy);
    else pass_cnt++;
    cyc = 0;
    while (busy && cyc < 100) begin
      we = 1'b1; wa = 5'd9; wd = $urandom;
      ra[0] = 5'($urandom_range(0, 31)); ra[1] = 5'($urandom_range(0, 31));
      #1;
      tot_cnt++;
      if (rd !== 64'h0) $display("FAIL clear_read_zero: cycle %0d got %h expected 0", cyc, rd);
      else pass_cnt++;
      tick();
      cyc++;
    end
    we = 1'b0;
    tot_cnt++;
    if (cyc !== 32) $display("FAIL clear_sweep_len: got %0d cycles expected 32", cyc);
    else pass_cnt++;
    for (int a = 0; a < 32; a++) mem_m[a] = 32'h0;
    ra[0] = 5'd3; ra[1] = 5'd4;
    #1;
    tot_cnt++;
    if (rd[0] !== mem_m[3] || rd[1] !== mem_m[4]) $display("FAIL clear_x3_x4: got %h/%h expected 0/0", rd[0], rd[1]);
    else pass_cnt++;
    ra[0] = 5'd9;
    #1;
    tot_cnt++;
    if (rd[0] !== mem_m[9]) $display("FAIL clear_x9: got %h expected 0", rd[0]);
    else pass_cnt++;
  endtask

  task automatic test_reset_midsweep();
    int cyc;
    logic [31:0] v;
    for (int a = 1; a < 16; a++) begin
      we2 = 1'b1; wa2 = 4'(a); wd2 = $urandom | 32'h1;
      tick();
      mem2_m[a] = wd2;
    end
    we2 = 1'b0; ra2[0] = 4'd1; ra2[1] = 4'd8; ra2[2] = 4'd15;
    #1;
    tot_cnt++;
    if (rd2[0] !== mem2_m[1] || rd2[1] !== mem2_m[8] || rd2[2] !== mem2_m[15])
      $display("FAIL small_preload: got %h/%h/%h expected %h/%h/%h", rd2[0], rd2[1], rd2[2], mem2_m[1], mem2_m[8], mem2_m[15]);
    else pass_cnt++;
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      tot_cnt++;
      if (busy2 !== 1'b1 || rd2 !== 96'h0) $display("FAIL small_sweep_pre: cycle %0d got busy=%b rd=%h expected 1/0", c, busy2, rd2);
      else pass_cnt++;
      tick();
    end
    rst2_n = 1'b0;
    #1;
    tot_cnt++;
    if (busy2 !== 1'b1 || rd2 !== 96'h0) $display("FAIL small_in_reset: got busy=%b rd=%h expected 1/0", busy2, rd2);
    else pass_cnt++;
    tick(); tick();
    rst2_n = 1'b1;
    cyc = 0;
    while (busy2 && cyc < 100) begin
      ra2[0] = 4'($urandom_range(0, 15)); ra2[1] = 4'($urandom_range(0, 15)); ra2[2] = 4'($urandom_range(0, 15));
      #1;
      tot_cnt++;
      if (rd2 !== 96'h0) $display("FAIL small_sweep_read: cycle %0d got %h expected 0", cyc, rd2);
      else pass_cnt++;
      tick();
      cyc++;
    end
    tot_cnt++;
    if (cyc !== 16) $display("FAIL small_sweep_len: got %0d cycles expected 16", cyc);
    else pass_cnt++;
    for (int a = 0; a < 16; a++) mem2_m[a] = 32'h0;
    for (int a = 0; a < 16; a++) begin
      ra2[0] = 4'(a); ra2[1] = 4'(15 - a); ra2[2] = 4'((a + 5) % 16);
      #1;
      tot_cnt++;
      if (rd2[0] !== mem2_m[a] || rd2[1] !== mem2_m[15 - a] || rd2[2] !== mem2_m[(a + 5) % 16])
        $display("FAIL small_after_clear: addr %0d got %h expected 0", a, rd2);
      else pass_cnt++;
    end
    v = $urandom;
    we2 = 1'b1; wa2 = 4'd2; wd2 = v;
    tick();
    mem2_m[2] = v;
    we2 = 1'b0; ra2[0] = 4'd2; ra2[1] = 4'd0; ra2[2] = 4'd2;
    #1;
    tot_cnt++;
    if (rd2[0] !== mem2_m[2] || rd2[1] !== 32'h0 || rd2[2] !== mem2_m[2])
      $display("FAIL small_write_after: got %h/%h/%h expected %h/0/%h", rd2[0], rd2[1], rd2[2], v, v);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; we = 1'b0; wa = '0; wd = '0; ra = '0;
    rst2_n = 1'b0; clr2 = 1'b0; we2 = 1'b0; wa2 = '0; wd2 = '0; ra2 = '0;
    test_reset();
    test_write_read();
    test_x0();
    test_bypass();
    test_random();
    test_clear();
    test_reset_midsweep();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
